// File: rtl/salu_wb_queue_if.sv
// Handshake/bus bundle between the SALU writeback stage, the SGPR write port and issue hazard probe.
// The slave modport is the queue itself; the master modport is whoever drives the SALU/arbiter side.
interface salu_wb_queue_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9,
    parameter int WFID_W = 6
);
    logic              enq_valid;
    logic [WFID_W-1:0] enq_wfid;
    logic [ADDR_W-1:0] enq_addr;
    logic [1:0]        enq_wr_en;
    logic [DATA_W-1:0] enq_data;
    logic              salu_ready;

    logic              rfa_request;
    logic              rfa_grant;
    logic [ADDR_W-1:0] sgpr_dest_addr;
    logic [DATA_W-1:0] sgpr_dest_data;
    logic [1:0]        sgpr_dest_wr_en;
    logic              sgpr_instr_done;
    logic [WFID_W-1:0] sgpr_instr_done_wfid;

    logic [WFID_W-1:0] lookup_wfid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;

    logic              err_overflow;

    modport slave (
        input  enq_valid, enq_wfid, enq_addr, enq_wr_en, enq_data,
        input  rfa_grant, lookup_wfid, lookup_addr,
        output salu_ready, rfa_request, sgpr_dest_addr, sgpr_dest_data,
        output sgpr_dest_wr_en, sgpr_instr_done, sgpr_instr_done_wfid,
        output lookup_hit, err_overflow
    );

    modport master (
        output enq_valid, enq_wfid, enq_addr, enq_wr_en, enq_data,
        output rfa_grant, lookup_wfid, lookup_addr,
        input  salu_ready, rfa_request, sgpr_dest_addr, sgpr_dest_data,
        input  sgpr_dest_wr_en, sgpr_instr_done, sgpr_instr_done_wfid,
        input  lookup_hit, err_overflow
    );
endinterface

// File: rtl/salu_wb_queue.sv
// SALU writeback buffer: queues SGPR writes, drains them in FIFO order on register-file grant,
// and answers a pending-write lookup so issue can hold off RAW hazards on queued SGPRs.
module salu_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9,
    parameter int WFID_W = 6,
    parameter int SKID   = 3
) (
    input  logic            clk,
    input  logic            rst,
    salu_wb_queue_if.slave  q
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    // Room must remain for SKID instructions already past issue when ready drops.
    localparam int THRESH = (SKID >= DEPTH) ? 0 : DEPTH - SKID;

    logic [WFID_W-1:0] ent_wfid  [DEPTH];
    logic [ADDR_W-1:0] ent_addr  [DEPTH];
    logic [1:0]        ent_wr_en [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];
    logic [DEPTH-1:0]  ent_valid;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              salu_ready_r;
    logic              err_overflow_r;

    logic              not_empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              overflow;
    logic              hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_empty  = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign pop        = not_empty & q.rfa_grant;
    assign push       = q.enq_valid & (|q.enq_wr_en) & (~full | pop);
    assign overflow   = q.enq_valid & (|q.enq_wr_en) & full & ~pop;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            ent_valid      <= '0;
            salu_ready_r   <= 1'b1;
            err_overflow_r <= 1'b0;
        end else begin
            // Clear before set: when full with a same-cycle pop, wr_ptr == rd_ptr and the new entry must survive.
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= ptr_inc(rd_ptr);
            end
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            count        <= count_next;
            salu_ready_r <= (count_next <= CNT_W'(THRESH));
            if (overflow)
                err_overflow_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_wfid[wr_ptr]  <= q.enq_wfid;
            ent_addr[wr_ptr]  <= q.enq_addr;
            ent_wr_en[wr_ptr] <= q.enq_wr_en;
            ent_data[wr_ptr]  <= q.enq_data;
        end
    end

    // A head being popped this cycle still counts: its write lands only at the end of the cycle.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_wfid[i] == q.lookup_wfid) &&
                ((ent_wr_en[i][0] && (ent_addr[i] == q.lookup_addr)) ||
                 (ent_wr_en[i][1] && ((ent_addr[i] + ADDR_W'(1)) == q.lookup_addr))))
                hit = 1'b1;
        end
    end

    assign q.salu_ready           = salu_ready_r;
    assign q.err_overflow         = err_overflow_r;
    assign q.rfa_request          = not_empty;
    assign q.sgpr_dest_addr       = not_empty ? ent_addr[rd_ptr] : '0;
    assign q.sgpr_dest_data       = not_empty ? ent_data[rd_ptr] : '0;
    assign q.sgpr_instr_done_wfid = not_empty ? ent_wfid[rd_ptr] : '0;
    assign q.sgpr_dest_wr_en      = pop ? ent_wr_en[rd_ptr] : 2'b00;
    assign q.sgpr_instr_done      = pop;
    assign q.lookup_hit           = hit;
endmodule

// File: tb/tb_salu_wb_queue.sv
// Directed bench for salu_wb_queue (DEPTH=4, SKID=3): commit order, ready threshold,
// full-with-pop, overflow, lookup wrap and mid-operation reset.
module tb_salu_wb_queue;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    salu_wb_queue_if #(.DATA_W(64), .ADDR_W(9), .WFID_W(6)) bus ();

    salu_wb_queue #(
        .DEPTH(4), .DATA_W(64), .ADDR_W(9), .WFID_W(6), .SKID(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic v, input logic [5:0] w, input logic [8:0] a,
                           input logic [1:0] we, input logic [63:0] d);
        bus.enq_valid = v;
        bus.enq_wfid  = w;
        bus.enq_addr  = a;
        bus.enq_wr_en = we;
        bus.enq_data  = d;
    endtask

    logic [8:0]  exp_addr [3];
    logic [5:0]  exp_wfid [3];
    logic [1:0]  exp_we   [3];
    logic [63:0] exp_data [3];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        set_enq(1'b0, '0, '0, 2'b00, '0);
        bus.rfa_grant   = 1'b0;
        bus.lookup_wfid = '0;
        bus.lookup_addr = '0;
        exp_addr = '{9'h010, 9'h020, 9'h030};
        exp_wfid = '{6'd1, 6'd2, 6'd3};
        exp_we   = '{2'b01, 2'b10, 2'b11};
        exp_data = '{64'h1111, 64'h2222, 64'h3333};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_request", bus.rfa_request, 0);
        check("rst_ready", bus.salu_ready, 1);
        check("rst_err", bus.err_overflow, 0);
        check("rst_done", bus.sgpr_instr_done, 0);
        check("rst_wr_en", bus.sgpr_dest_wr_en, 0);
        check("rst_addr", bus.sgpr_dest_addr, 0);

        // Grant on an empty queue does nothing.
        bus.rfa_grant = 1'b1;
        #1;
        check("empty_grant_wr_en", bus.sgpr_dest_wr_en, 0);
        check("empty_grant_done", bus.sgpr_instr_done, 0);
        tick();
        check("empty_grant_req", bus.rfa_request, 0);
        check("empty_grant_ready", bus.salu_ready, 1);
        bus.rfa_grant = 1'b0;

        // Three writes, then drain with grant held.
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, exp_wfid[i], exp_addr[i], exp_we[i], exp_data[i]);
            tick();
        end
        set_enq(1'b0, '0, '0, 2'b00, '0);
        #1;
        check("three_ready", bus.salu_ready, 0);
        bus.rfa_grant = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("drain_addr", bus.sgpr_dest_addr, 64'(exp_addr[i]));
            check("drain_data", bus.sgpr_dest_data, exp_data[i]);
            check("drain_wfid", bus.sgpr_instr_done_wfid, 64'(exp_wfid[i]));
            check("drain_wr_en", bus.sgpr_dest_wr_en, 64'(exp_we[i]));
            check("drain_done", bus.sgpr_instr_done, 1);
            tick();
        end
        check("drained_req", bus.rfa_request, 0);
        check("drained_done", bus.sgpr_instr_done, 0);
        check("drained_ready", bus.salu_ready, 1);
        bus.rfa_grant = 1'b0;

        // Ready threshold: DEPTH-SKID = 1.
        set_enq(1'b1, 6'd9, 9'h021, 2'b01, 64'hA1);
        tick();
        check("thr_ready_1", bus.salu_ready, 1);
        set_enq(1'b1, 6'd9, 9'h022, 2'b01, 64'hA2);
        tick();
        check("thr_ready_2", bus.salu_ready, 0);
        set_enq(1'b0, '0, '0, 2'b00, '0);
        bus.rfa_grant = 1'b1;
        tick();
        check("thr_ready_after_pop", bus.salu_ready, 1);
        check("thr_head_addr", bus.sgpr_dest_addr, 64'h022);
        tick();
        check("thr_empty_req", bus.rfa_request, 0);
        bus.rfa_grant = 1'b0;

        // Full plus simultaneous enq and pop.
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 6'd7, 9'(9'h040 + i), 2'b01, 64'h4000 + 64'(i));
            tick();
        end
        check("full_ready", bus.salu_ready, 0);
        check("full_req", bus.rfa_request, 1);
        set_enq(1'b1, 6'd7, 9'h044, 2'b01, 64'h4004);
        bus.rfa_grant = 1'b1;
        #1;
        check("full_pop_addr", bus.sgpr_dest_addr, 64'h040);
        check("full_pop_done", bus.sgpr_instr_done, 1);
        tick();
        set_enq(1'b0, '0, '0, 2'b00, '0);
        #1;
        check("full_pop_err", bus.err_overflow, 0);
        for (int i = 1; i < 5; i++) begin
            check("full_drain_addr", bus.sgpr_dest_addr, 64'h040 + 64'(i));
            check("full_drain_data", bus.sgpr_dest_data, 64'h4000 + 64'(i));
            tick();
        end
        check("full_drain_empty", bus.rfa_request, 0);
        bus.rfa_grant = 1'b0;

        // Overflow: enq while full, no grant.
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 6'd3, 9'(9'h050 + i), 2'b11, 64'h5000 + 64'(i));
            tick();
        end
        set_enq(1'b1, 6'd3, 9'h099, 2'b11, 64'hDEAD_BEEF);
        tick();
        set_enq(1'b0, '0, '0, 2'b00, '0);
        #1;
        check("ovf_err_set", bus.err_overflow, 1);
        bus.rfa_grant = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_data", bus.sgpr_dest_data, 64'h5000 + 64'(i));
            check("ovf_drain_addr", bus.sgpr_dest_addr, 64'h050 + 64'(i));
            tick();
        end
        check("ovf_drain_empty", bus.rfa_request, 0);
        check("ovf_err_sticky", bus.err_overflow, 1);
        bus.rfa_grant = 1'b0;

        // Lookup, including addr+1 wrap.
        set_enq(1'b1, 6'd5, 9'h1FF, 2'b11, 64'h77);
        tick();
        set_enq(1'b1, 6'd4, 9'h100, 2'b01, 64'h88);
        tick();
        set_enq(1'b0, '0, '0, 2'b00, '0);
        bus.lookup_wfid = 6'd5; bus.lookup_addr = 9'h1FF; #1;
        check("lk_5_1ff", bus.lookup_hit, 1);
        bus.lookup_wfid = 6'd5; bus.lookup_addr = 9'h000; #1;
        check("lk_5_000_wrap", bus.lookup_hit, 1);
        bus.lookup_wfid = 6'd4; bus.lookup_addr = 9'h1FF; #1;
        check("lk_4_1ff", bus.lookup_hit, 0);
        bus.lookup_wfid = 6'd4; bus.lookup_addr = 9'h100; #1;
        check("lk_4_100", bus.lookup_hit, 1);
        bus.lookup_wfid = 6'd4; bus.lookup_addr = 9'h101; #1;
        check("lk_4_101_hi_off", bus.lookup_hit, 0);

        // Reset with two entries queued: nothing must be written afterwards.
        rst = 1'b1;
        #1;
        check("midrst_req", bus.rfa_request, 0);
        check("midrst_err", bus.err_overflow, 0);
        check("midrst_lookup", bus.lookup_hit, 0);
        tick();
        rst = 1'b0;
        bus.rfa_grant = 1'b1;
        #1;
        check("post_rst_wr_en", bus.sgpr_dest_wr_en, 0);
        check("post_rst_done", bus.sgpr_instr_done, 0);
        check("post_rst_ready", bus.salu_ready, 1);
        tick();
        check("post_rst_done2", bus.sgpr_instr_done, 0);
        check("post_rst_req2", bus.rfa_request, 0);
        bus.rfa_grant = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
